// File: rtl/pipelined_cl_adder.sv
// Pipelined add/subtract: operands split into Stages chunks, one carry-lookahead
// chunk resolves per clock with the inter-chunk carry registered.
module pipelined_cl_adder #(
    parameter int unsigned Width  = 16,
    parameter int unsigned Stages = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    input  logic             carry_i,
    input  logic             sub_i,
    output logic             valid_o,
    output logic [Width-1:0] result_o,
    output logic             carry_o,
    output logic             overflow_o
);

    localparam int unsigned ChunkWidth = Width / Stages;
    localparam int unsigned Last       = Stages - 1;

    if ((Width % Stages) != 0) begin : g_bad_cfg
        $error("pipelined_cl_adder: Width must be a multiple of Stages");
    end

    function automatic logic [ChunkWidth:0] cla_add(
        input logic [ChunkWidth-1:0] x,
        input logic [ChunkWidth-1:0] y,
        input logic                  cin
    );
        logic [ChunkWidth-1:0] g;
        logic [ChunkWidth-1:0] p;
        logic [ChunkWidth:0]   c;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < ChunkWidth; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        return {c[ChunkWidth], p ^ c[ChunkWidth-1:0]};
    endfunction

    // Stage k inputs (_s) come from stage k-1 registers (_q); stage 0 from the ports.
    // Operand registers carry the still-unused upper chunks; result registers the
    // already-resolved lower chunks.
    logic [Width-1:0]      a_s       [Stages];
    logic [Width-1:0]      b_s       [Stages];
    logic [Width-1:0]      r_s       [Stages];
    logic                  c_s       [Stages];
    logic                  v_s       [Stages];
    logic [Width-1:0]      r_n       [Stages];
    logic [ChunkWidth:0]   chunk_sum [Stages];

    logic [Width-1:0]      a_q       [Stages];
    logic [Width-1:0]      b_q       [Stages];
    logic [Width-1:0]      r_q       [Stages];
    logic                  c_q       [Stages];
    logic                  v_q       [Stages];

    always_comb begin
        a_s[0] = a_i;
        b_s[0] = sub_i ? ~b_i : b_i;
        r_s[0] = '0;
        c_s[0] = carry_i ^ sub_i;
        v_s[0] = valid_i;
        for (int unsigned k = 1; k < Stages; k++) begin
            a_s[k] = a_q[k-1];
            b_s[k] = b_q[k-1];
            r_s[k] = r_q[k-1];
            c_s[k] = c_q[k-1];
            v_s[k] = v_q[k-1];
        end
        for (int unsigned k = 0; k < Stages; k++) begin
            chunk_sum[k] = cla_add(a_s[k][k*ChunkWidth +: ChunkWidth],
                                   b_s[k][k*ChunkWidth +: ChunkWidth],
                                   c_s[k]);
            r_n[k] = r_s[k];
            r_n[k][k*ChunkWidth +: ChunkWidth] = chunk_sum[k][ChunkWidth-1:0];
        end
    end

    // Data registers advance on bubbles too so bubble-slot outputs stay deterministic.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned k = 0; k < Stages; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                r_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
        end else if (en_i) begin
            for (int unsigned k = 0; k < Stages; k++) begin
                a_q[k] <= a_s[k];
                b_q[k] <= b_s[k];
                r_q[k] <= r_n[k];
                c_q[k] <= chunk_sum[k][ChunkWidth];
                v_q[k] <= v_s[k];
            end
        end
    end

    assign valid_o  = v_q[Last];
    assign result_o = r_q[Last];
    assign carry_o  = c_q[Last];
    // Overflow from registered MSBs only: operands agree in sign, result differs.
    assign overflow_o = (a_q[Last][Width-1] == b_q[Last][Width-1]) &&
                        (r_q[Last][Width-1] != a_q[Last][Width-1]);

endmodule

// File: tb/tb_pipelined_cl_adder.sv
// Scoreboard bench for pipelined_cl_adder: Stages=4 instance checked slot-accurately,
// Stages=1 instance checked for single-cycle latency.
module tb_pipelined_cl_adder;

    localparam int unsigned W = 16;
    localparam int unsigned S = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b1;
    logic          valid = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          carry_in = 1'b0;
    logic          sub = 1'b0;

    logic          valid_o;
    logic [W-1:0]  result_o;
    logic          carry_o;
    logic          overflow_o;
    logic          s1_valid;
    logic [W-1:0]  s1_result;
    logic          s1_carry;
    logic          s1_ovf;

    pipelined_cl_adder #(.Width(W), .Stages(S)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .valid_i(valid),
        .a_i(a), .b_i(b), .carry_i(carry_in), .sub_i(sub),
        .valid_o(valid_o), .result_o(result_o), .carry_o(carry_o), .overflow_o(overflow_o)
    );

    pipelined_cl_adder #(.Width(W), .Stages(1)) dut_s1 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .valid_i(valid),
        .a_i(a), .b_i(b), .carry_i(carry_in), .sub_i(sub),
        .valid_o(s1_valid), .result_o(s1_result), .carry_o(s1_carry), .overflow_o(s1_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         o;
        int           due;
    } exp_t;

    exp_t         sb[$];
    exp_t         held;
    logic         held_v = 1'b0;
    int           adv_cnt = 0;
    int           total = 0;
    int           bad = 0;
    logic [W-1:0] pend_r = '0;
    logic         pend_c = 1'b0;
    logic         pend_o = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W+1:0] ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                                input logic ci, input logic s);
        logic [W-1:0] ye;
        logic [W:0]   sum;
        logic         ov;
        ye  = s ? ~y : y;
        sum = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, ci ^ s};
        ov  = (x[W-1] == ye[W-1]) && (sum[W-1] != x[W-1]);
        return {ov, sum[W], sum[W-1:0]};
    endfunction

    // One clock: push the presented op at the edge, then check the DUT just after it.
    task automatic cycle();
        exp_t e;
        logic did_rst;
        logic did_adv;
        logic exp_v;
        @(posedge clk);
        did_rst = rst;
        did_adv = en && !rst;
        if (did_rst) begin
            sb.delete();
        end else if (did_adv) begin
            adv_cnt++;
            if (valid) begin
                e.r = pend_r; e.c = pend_c; e.o = pend_o; e.due = adv_cnt + S - 1;
                sb.push_back(e);
            end
        end
        #1;
        if (did_rst) begin
            check("rst_valid", {31'd0, valid_o}, 32'd0);
            check("rst_result", {16'd0, result_o}, 32'd0);
            check("rst_carry", {31'd0, carry_o}, 32'd0);
            check("rst_ovf", {31'd0, overflow_o}, 32'd0);
            held_v = 1'b0;
        end else if (did_adv) begin
            exp_v = (sb.size() > 0) && (sb[0].due == adv_cnt);
            check("valid", {31'd0, valid_o}, {31'd0, exp_v});
            if (exp_v) begin
                e = sb.pop_front();
                check("result", {16'd0, result_o}, {16'd0, e.r});
                check("carry", {31'd0, carry_o}, {31'd0, e.c});
                check("ovf", {31'd0, overflow_o}, {31'd0, e.o});
                held = e;
            end
            held_v = exp_v;
        end else begin
            check("stall_valid", {31'd0, valid_o}, {31'd0, held_v});
            if (held_v) begin
                check("stall_result", {16'd0, result_o}, {16'd0, held.r});
                check("stall_carry", {31'd0, carry_o}, {31'd0, held.c});
                check("stall_ovf", {31'd0, overflow_o}, {31'd0, held.o});
            end
        end
    endtask

    task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic s);
        logic [W+1:0] m;
        a = x; b = y; carry_in = ci; sub = s; valid = 1'b1;
        m = ref_model(x, y, ci, s);
        pend_r = m[W-1:0]; pend_c = m[W]; pend_o = m[W+1];
        cycle();
    endtask

    task automatic op_k(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic s,
                        input logic [W-1:0] er, input logic ec, input logic eo);
        a = x; b = y; carry_in = ci; sub = s; valid = 1'b1;
        pend_r = er; pend_c = ec; pend_o = eo;
        cycle();
    endtask

    task automatic rand_op();
        op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic drain(input int n);
        valid = 1'b0;
        a = W'($urandom); b = W'($urandom);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with an op presented: it must be dropped.
        rst = 1'b1; en = 1'b1;
        op_k(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
        cycle();
        check("s1_rst_valid", {31'd0, s1_valid}, 32'd0);
        check("s1_rst_result", {16'd0, s1_result}, 32'd0);
        rst = 1'b0;
        drain(5);

        op_k(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        drain(5);

        op_k(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        op_k(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        op_k(16'h0004, 16'h000F, 1'b0, 1'b1, 16'hFFF5, 1'b0, 1'b0);
        op_k(16'h0004, 16'h000F, 1'b1, 1'b1, 16'hFFF4, 1'b0, 1'b0);
        op_k(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        op_k(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        drain(5);

        // Random stream with a single bubble in slot 4.
        for (int i = 0; i < 9; i++) begin
            if (i == 4) drain(1);
            else rand_op();
        end
        drain(5);

        // Stall with two ops in flight; inputs during stall are ignored.
        rand_op(); rand_op();
        en = 1'b0;
        for (int i = 0; i < 3; i++) rand_op();
        en = 1'b1;
        drain(6);

        // Stall while a result is sitting on the outputs.
        for (int i = 0; i < 4; i++) rand_op();
        en = 1'b0;
        for (int i = 0; i < 3; i++) rand_op();
        en = 1'b1;
        rand_op(); rand_op();
        drain(6);

        // Reset with three ops in flight plus one presented alongside reset.
        rand_op(); rand_op(); rand_op();
        rst = 1'b1;
        rand_op();
        rst = 1'b0;
        drain(6);

        // Single-stage instance: result one edge after capture.
        op_k(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        check("s1_valid", {31'd0, s1_valid}, 32'd1);
        check("s1_result", {16'd0, s1_result}, 32'h0100);
        check("s1_carry", {31'd0, s1_carry}, 32'd0);
        check("s1_ovf", {31'd0, s1_ovf}, 32'd0);
        op_k(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        check("s1_sub_result", {16'd0, s1_result}, 32'h7FFF);
        check("s1_sub_carry", {31'd0, s1_carry}, 32'd1);
        check("s1_sub_ovf", {31'd0, s1_ovf}, 32'd1);
        drain(1);
        check("s1_bubble_valid", {31'd0, s1_valid}, 32'd0);
        drain(5);

        check("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
